ssd_scan_driver: RTL and testbench

Parametrised seven-segment display driver. Converts a binary value to BCD with a sequential double-dabble engine, then time-multiplexes the result across `NUM_DIGITS` active-low anodes. Supports leading-zero blanking, per-digit decimal points and overflow indication. It replaces the fixed two-digit score display in the game top level and can drive all eight digits of the board.

---
 rtl/ssd_pkg.sv | 57 +++++
 rtl/bin2bcd_seq.sv | 112 +++++++++++
 rtl/ssd_scan_driver.sv | 121 ++++++++++++
 tb/tb_ssd_scan_driver.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan driver: segment patterns,
// conversion FSM states and small constant/datapath helpers.
package ssd_pkg;

   // Active-low segment patterns, ordered {a,b,c,d,e,f,g}
   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b1111110;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONVERT = 2'd1,
      ST_COMMIT  = 2'd2
   } state_t;

   function automatic logic [63:0] pow10(input int unsigned n);
      logic [63:0] r;
      r = 64'd1;
      for (int unsigned k = 0; k < n; k++) begin
         r = r * 64'd10;
      end
      return r;
   endfunction

   // Double-dabble correction applied to one BCD nibble before each shift
   function automatic logic [3:0] add3(input logic [3:0] n);
      return (n >= 4'd5) ? (n + 4'd3) : n;
   endfunction

   function automatic logic [6:0] digit_seg(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with overflow detection.
// One shift per cycle; result is presented on Bcd while Bcd_Valid is high.
module bin2bcd_seq
   import ssd_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 8,
   parameter int unsigned VALUE_W    = 16
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic                      Load,
   input  logic [VALUE_W-1:0]        Value,
   output logic                      Busy,
   output logic [4*NUM_DIGITS-1:0]   Bcd,
   output logic                      Bcd_Valid,
   output logic                      Overflow
);

   localparam int unsigned BCD_W   = 4 * NUM_DIGITS;
   localparam int unsigned SHIFT_W = BCD_W + VALUE_W;
   localparam int unsigned CNT_W   = $clog2(VALUE_W + 1);
   localparam logic [63:0] MAX_VAL = pow10(NUM_DIGITS) - 64'd1;

   state_t               r_state;
   state_t               w_next_state;
   logic [VALUE_W-1:0]   r_bin;
   logic [VALUE_W-1:0]   w_bin_next;
   logic [BCD_W-1:0]     r_bcd;
   logic [BCD_W-1:0]     w_bcd_next;
   logic [BCD_W-1:0]     w_bcd_adj;
   logic [SHIFT_W-1:0]   w_shift;
   logic [CNT_W-1:0]     r_cnt;
   logic [CNT_W-1:0]     w_cnt_next;
   logic                 r_ovf_pend;
   logic                 w_ovf_pend_next;
   logic                 r_ovf;
   logic                 w_ovf_next;
   logic                 r_busy;
   logic                 r_valid;

   // State and datapath registers
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state    <= ST_IDLE;
         r_bin      <= '0;
         r_bcd      <= '0;
         r_cnt      <= '0;
         r_ovf_pend <= 1'b0;
         r_ovf      <= 1'b0;
         r_busy     <= 1'b0;
         r_valid    <= 1'b0;
      end else begin
         r_state    <= w_next_state;
         r_bin      <= w_bin_next;
         r_bcd      <= w_bcd_next;
         r_cnt      <= w_cnt_next;
         r_ovf_pend <= w_ovf_pend_next;
         r_ovf      <= w_ovf_next;
         r_busy     <= (w_next_state != ST_IDLE);
         r_valid    <= (w_next_state == ST_COMMIT);
      end
   end

   // Next-state and datapath logic
   always_comb begin
      w_next_state    = r_state;
      w_bin_next      = r_bin;
      w_bcd_next      = r_bcd;
      w_cnt_next      = r_cnt;
      w_ovf_pend_next = r_ovf_pend;
      w_ovf_next      = r_ovf;
      w_bcd_adj       = r_bcd;

      for (int d = 0; d < int'(NUM_DIGITS); d++) begin
         w_bcd_adj[4*d +: 4] = add3(r_bcd[4*d +: 4]);
      end
      w_shift = {w_bcd_adj, r_bin} << 1;

      case (r_state)
         ST_IDLE: begin
            if (Load) begin
               w_bin_next      = Value;
               w_bcd_next      = '0;
               w_cnt_next      = CNT_W'(VALUE_W);
               w_ovf_pend_next = (64'(Value) > MAX_VAL);
               w_next_state    = ST_CONVERT;
            end
         end
         ST_CONVERT: begin
            w_bcd_next = w_shift[SHIFT_W-1:VALUE_W];
            w_bin_next = w_shift[VALUE_W-1:0];
            w_cnt_next = r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
               w_next_state = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            w_ovf_next   = r_ovf_pend;
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   assign Busy      = r_busy;
   assign Bcd       = r_bcd;
   assign Bcd_Valid = r_valid;
   assign Overflow  = r_ovf;

endmodule

// File: rtl/ssd_scan_driver.sv
// Seven-segment display driver: converts a binary value to BCD and scans it
// across active-low anodes with leading-zero blanking, decimal points and overflow dashes.
module ssd_scan_driver
   import ssd_pkg::*;
#(
   parameter int unsigned NUM_DIGITS     = 8,
   parameter int unsigned VALUE_W        = 16,
   parameter int unsigned REFRESH_CYCLES = 100000
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic [VALUE_W-1:0]      Value,
   input  logic                    Load,
   input  logic                    Blank_Leading,
   input  logic [NUM_DIGITS-1:0]   Dp_Mask,
   output logic                    Busy,
   output logic                    Overflow,
   output logic [NUM_DIGITS-1:0]   Anodes,
   output logic [7:0]              Cathodes
);

   localparam int unsigned BCD_W = 4 * NUM_DIGITS;
   localparam int unsigned REF_W = $clog2(REFRESH_CYCLES);
   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   logic                   w_busy;
   logic [BCD_W-1:0]       w_bcd;
   logic                   w_bcd_valid;
   logic                   w_ovf;

   logic [REF_W-1:0]       r_ref;
   logic [IDX_W-1:0]       r_idx;
   logic [BCD_W-1:0]       r_disp;
   logic [NUM_DIGITS-1:0]  r_anodes;
   logic [7:0]             r_cathodes;

   logic [3:0]             w_nib;
   logic                   w_upper_zero;
   logic                   w_blank;
   logic                   w_dp;
   logic [6:0]             w_seg;
   logic [NUM_DIGITS-1:0]  w_anodes_next;

   bin2bcd_seq #(
      .NUM_DIGITS (NUM_DIGITS),
      .VALUE_W    (VALUE_W)
   ) u_bin2bcd (
      .Clk       (Clk),
      .Reset     (Reset),
      .Load      (Load),
      .Value     (Value),
      .Busy      (w_busy),
      .Bcd       (w_bcd),
      .Bcd_Valid (w_bcd_valid),
      .Overflow  (w_ovf)
   );

   // Refresh counter and digit index; runs regardless of conversion activity
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_ref <= '0;
         r_idx <= '0;
      end else if (r_ref == REF_W'(REFRESH_CYCLES - 1)) begin
         r_ref <= '0;
         r_idx <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : (r_idx + IDX_W'(1));
      end else begin
         r_ref <= r_ref + REF_W'(1);
      end
   end

   // Display register only changes on a completed conversion
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_disp <= '0;
      end else if (w_bcd_valid) begin
         r_disp <= w_bcd;
      end
   end

   // Digit select, blanking and segment decode for the current index
   always_comb begin
      w_nib         = 4'd0;
      w_upper_zero  = 1'b1;
      w_dp          = 1'b1;
      w_anodes_next = '1;
      for (int d = 0; d < int'(NUM_DIGITS); d++) begin
         if (IDX_W'(d) == r_idx) begin
            w_nib            = r_disp[4*d +: 4];
            w_dp             = ~Dp_Mask[d];
            w_anodes_next[d] = 1'b0;
         end
         if ((IDX_W'(d) >= r_idx) && (r_disp[4*d +: 4] != 4'd0)) begin
            w_upper_zero = 1'b0;
         end
      end
      w_blank = Blank_Leading && (r_idx != '0) && w_upper_zero;
      if (w_ovf) begin
         w_seg = SEG_DASH;
      end else if (w_blank) begin
         w_seg = SEG_BLANK;
      end else begin
         w_seg = digit_seg(w_nib);
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_anodes   <= '1;
         r_cathodes <= 8'hFF;
      end else begin
         r_anodes   <= w_anodes_next;
         r_cathodes <= {w_seg, w_dp};
      end
   end

   assign Busy     = w_busy;
   assign Overflow = w_ovf;
   assign Anodes   = r_anodes;
   assign Cathodes = r_cathodes;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed self-checking bench for ssd_scan_driver: a 4-digit instance for the
// main scenarios and an 8-digit instance for the wide-value scan.
module tb_ssd_scan_driver;

   localparam int unsigned ND  = 4;
   localparam int unsigned VW  = 14;
   localparam int unsigned RC  = 4;
   localparam int unsigned ND2 = 8;
   localparam int unsigned VW2 = 27;

   logic            clk;
   logic            rst;
   logic [VW-1:0]   value;
   logic            load;
   logic            blank;
   logic [ND-1:0]   dp;
   logic            busy;
   logic            ovf;
   logic [ND-1:0]   anodes;
   logic [7:0]      cathodes;

   logic [VW2-1:0]  value2;
   logic            load2;
   logic            blank2;
   logic [ND2-1:0]  dp2;
   logic            busy2;
   logic            ovf2;
   logic [ND2-1:0]  anodes2;
   logic [7:0]      cathodes2;

   int n_chk;
   int n_pass;

   ssd_scan_driver #(.NUM_DIGITS(ND), .VALUE_W(VW), .REFRESH_CYCLES(RC)) dut (
      .Clk(clk), .Reset(rst), .Value(value), .Load(load),
      .Blank_Leading(blank), .Dp_Mask(dp), .Busy(busy), .Overflow(ovf),
      .Anodes(anodes), .Cathodes(cathodes)
   );

   ssd_scan_driver #(.NUM_DIGITS(ND2), .VALUE_W(VW2), .REFRESH_CYCLES(RC)) dut2 (
      .Clk(clk), .Reset(rst), .Value(value2), .Load(load2),
      .Blank_Leading(blank2), .Dp_Mask(dp2), .Busy(busy2), .Overflow(ovf2),
      .Anodes(anodes2), .Cathodes(cathodes2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
   endtask

   // Pulse Load, optionally re-pulse while busy, count busy cycles, then one more edge
   task automatic run_load(input logic [VW-1:0] v, input int inj_at,
                           input logic [VW-1:0] inj_v, output int cycles);
      value = v;
      load  = 1'b1;
      tick();
      load   = 1'b0;
      cycles = 0;
      while (busy === 1'b1 && cycles < 100) begin
         if (cycles == inj_at) begin
            value = inj_v;
            load  = 1'b1;
         end
         cycles++;
         tick();
         load = 1'b0;
      end
      tick();
   endtask

   task automatic wait_dwell(input logic [ND-1:0] pat, input string tag);
      logic [ND-1:0] prev;
      int            found;
      prev  = anodes;
      found = 0;
      for (int i = 0; i < 40 && found == 0; i++) begin
         tick();
         if (anodes === pat && prev !== pat) found = 1;
         prev = anodes;
      end
      check({tag, "_found"}, 32'(found), 32'd1);
   endtask

   task automatic show_digit(input int i, input logic [7:0] exp, input string tag);
      logic [ND-1:0] p;
      p = ~(ND'(1) << i);
      wait_dwell(p, tag);
      check(tag, 32'(cathodes), 32'(exp));
   endtask

   initial begin
      logic [7:0]     t1c [4];
      logic [ND-1:0]  t1a [4];
      logic [ND2-1:0] pat2;
      logic [ND2-1:0] prev2;
      int             n;
      int             found;

      t1c = '{8'b10011001, 8'b00001101, 8'b00100101, 8'b10011111};
      t1a = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      n_chk  = 0;
      n_pass = 0;
      rst    = 1'b1;
      value  = '0;
      load   = 1'b0;
      blank  = 1'b0;
      dp     = '0;
      value2 = '0;
      load2  = 1'b0;
      blank2 = 1'b0;
      dp2    = '0;

      // Reset state
      tick();
      tick();
      check("rst_anodes", 32'(anodes), 32'b1111);
      check("rst_cath", 32'(cathodes), 32'hFF);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      rst = 1'b0;
      tick();
      check("first_anodes", 32'(anodes), 32'b1110);
      check("first_cath", 32'(cathodes), 32'b00000011);

      // 1: value 1234 and full scan order with 4-cycle dwell
      run_load(14'd1234, -1, '0, n);
      check("t1_busy_len", 32'(n), 32'd15);
      wait_dwell(4'b1110, "t1_sync");
      for (int k = 0; k < 5; k++) begin
         for (int c = 0; c < 4; c++) begin
            check("t1_anodes", 32'(anodes), 32'(t1a[k % 4]));
            check("t1_cath", 32'(cathodes), 32'(t1c[k % 4]));
            tick();
         end
      end

      // 2: value 7, blanking and decimal point
      blank = 1'b1;
      dp    = 4'b0010;
      run_load(14'd7, -1, '0, n);
      check("t2_busy_len", 32'(n), 32'd15);
      show_digit(0, 8'b00011111, "t2_d0");
      show_digit(1, 8'b11111110, "t2_d1_blank");
      show_digit(2, 8'b11111111, "t2_d2_blank");
      show_digit(3, 8'b11111111, "t2_d3_blank");
      blank = 1'b0;
      show_digit(1, 8'b00000010, "t2_d1_noblank");
      show_digit(2, 8'b00000011, "t2_d2_noblank");
      show_digit(3, 8'b00000011, "t2_d3_noblank");

      // 3: overflow boundary
      dp = '0;
      run_load(14'd10000, -1, '0, n);
      check("t3_ovf_set", 32'(ovf), 32'd1);
      show_digit(0, 8'b11111101, "t3_d0_dash");
      show_digit(1, 8'b11111101, "t3_d1_dash");
      show_digit(2, 8'b11111101, "t3_d2_dash");
      blank = 1'b1;
      show_digit(3, 8'b11111101, "t3_d3_dash_blank");
      run_load(14'd0, -1, '0, n);
      check("t3_ovf_clr", 32'(ovf), 32'd0);
      show_digit(0, 8'b00000011, "t3_zero_d0");
      show_digit(1, 8'b11111111, "t3_zero_d1_blank");
      run_load(14'd9999, -1, '0, n);
      check("t3_9999_ovf", 32'(ovf), 32'd0);
      show_digit(3, 8'b00001001, "t3_9999_d3");
      show_digit(0, 8'b00001001, "t3_9999_d0");
      blank = 1'b0;

      // 4: Load while busy is dropped
      run_load(14'd42, 3, 14'd99, n);
      check("t4_busy_len", 32'(n), 32'd15);
      tick();
      tick();
      tick();
      check("t4_no_requeue", 32'(busy), 32'd0);
      show_digit(0, 8'b00100101, "t4_d0");
      show_digit(1, 8'b10011001, "t4_d1");

      // 5: reset in the 5th CONVERT cycle aborts without committing
      value = 14'd9999;
      load  = 1'b1;
      tick();
      load = 1'b0;
      check("t5_busy_pre", 32'(busy), 32'd1);
      tick();
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_anodes_off", 32'(anodes), 32'b1111);
      check("t5_cath_off", 32'(cathodes), 32'hFF);
      check("t5_ovf", 32'(ovf), 32'd0);
      tick();
      check("t5_idx0", 32'(anodes), 32'b1110);
      check("t5_d0", 32'(cathodes), 32'b00000011);
      for (int c = 0; c < 3; c++) begin
         tick();
         check("t5_dwell0", 32'(anodes), 32'b1110);
      end
      tick();
      check("t5_idx1", 32'(anodes), 32'b1101);
      check("t5_d1", 32'(cathodes), 32'b00000011);
      for (int c = 0; c < 20; c++) tick();
      check("t5_still_idle", 32'(busy), 32'd0);
      show_digit(3, 8'b00000011, "t5_d3_kept");

      // 6: eight digits, 27-bit value
      value2 = 27'd99999999;
      load2  = 1'b1;
      tick();
      load2 = 1'b0;
      n     = 0;
      while (busy2 === 1'b1 && n < 100) begin
         n++;
         tick();
      end
      tick();
      check("t6_busy_len", 32'(n), 32'd28);
      check("t6_ovf", 32'(ovf2), 32'd0);
      prev2 = anodes2;
      found = 0;
      for (int i = 0; i < 80 && found == 0; i++) begin
         tick();
         if (anodes2 === 8'hFE && prev2 !== 8'hFE) found = 1;
         prev2 = anodes2;
      end
      check("t6_sync_found", 32'(found), 32'd1);
      for (int k = 0; k < 9; k++) begin
         pat2 = ~(ND2'(1) << (k % 8));
         for (int c = 0; c < 4; c++) begin
            check("t6_anodes", 32'(anodes2), 32'(pat2));
            check("t6_cath", 32'(cathodes2), 32'b00001001);
            tick();
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
